aes_inv_key_expand: RTL and testbench

AES_INV_KEY_EXPAND -- requirements
Module: aes_inv_key_expand

---
 rtl/aes_inv_key_expand_if.sv | 54 +++++
 rtl/aes_inv_key_expand.sv | 202 ++++++++++++++++++++
 tb/tb_aes_inv_key_expand.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_key_expand_if.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expand_if
// Groups the request/response signals of the inverse AES-128 key schedule
// generator. Clock and reset are plain ports on the module and are not
// carried here.
//
// Signals:
//   start      - request to begin a schedule (driven by master)
//   key_in     - 128-bit seed key, word 0 in [127:96] (driven by master)
//   key_ready  - consumer accepts round_key when high (driven by master)
//   round_key  - current round key, same word order as key_in
//   round_idx  - round number of round_key, 10 down to 0
//   key_valid  - round_key/round_idx are valid
//   busy       - generator is not idle
//   done       - one-cycle pulse after round 0 has been accepted
//
// Modports:
//   master - the side that requests schedules and consumes keys
//   slave  - the key schedule generator itself
// ---------------------------------------------------------------------------
interface aes_inv_key_expand_if;

   logic         start;
   logic [127:0] key_in;
   logic         key_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         busy;
   logic         done;

   modport master (
      output start,
      output key_in,
      output key_ready,
      input  round_key,
      input  round_idx,
      input  key_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  key_in,
      input  key_ready,
      output round_key,
      output round_idx,
      output key_valid,
      output busy,
      output done
   );

endinterface

// File: rtl/aes_inv_key_expand.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expand
// Produces the AES-128 round keys in reverse order (round 10 down to round 0)
// for a decryption datapath, one key per key_valid/key_ready handshake.
// Each step walks the key schedule backwards from the key currently shown,
// so only one 128-bit key register is needed.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - aes_inv_key_expand_if.slave (start, key_in, key_ready,
//            round_key, round_idx, key_valid, busy, done)
//
// Build option:
//   AES_INV_KEY_CIPHER_KEY_EN - when defined, key_in is the cipher key and
//   the block first runs the forward expansion for 10 cycles (PRECOMP) to
//   reach the round-10 key. When undefined, key_in already is the round-10
//   key and is presented the cycle after start.
// ---------------------------------------------------------------------------
module aes_inv_key_expand (
   input  logic                  clk,
   input  logic                  rst_n,
   aes_inv_key_expand_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRECOMP = 2'd1,
      OUT     = 2'd2
   } state_t;

   // FIPS-197 forward S-box, entry 0 is the leftmost byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   state_t         state_q;
   state_t         state_d;
   logic [127:0]   round_key_q;
   logic [3:0]     round_idx_q;
   logic           done_q;

   logic [31:0]    w0, w1, w2, w3;
   logic [31:0]    inv0, inv1, inv2, inv3;
   logic [127:0]   inv_key;

   // SubWord(RotWord(w)): rotate left by one byte, then S-box every byte.
   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      logic [31:0] r;
      r = {w[23:0], w[31:24]};
      return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
   endfunction

   // Round constant for rounds 1..10 placed in the top byte of a word.
   function automatic logic [31:0] rcon_word(input logic [3:0] i);
      logic [7:0] rc;
      case (i)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h000000};
   endfunction

   assign w0 = round_key_q[127:96];
   assign w1 = round_key_q[95:64];
   assign w2 = round_key_q[63:32];
   assign w3 = round_key_q[31:0];

   // Inverse schedule step: undo the forward XOR chain from the top word
   // down, then recover word 0 using the already-recovered previous word 3.
   assign inv3    = w3 ^ w2;
   assign inv2    = w2 ^ w1;
   assign inv1    = w1 ^ w0;
   assign inv0    = w0 ^ sub_rot(inv3) ^ rcon_word(round_idx_q);
   assign inv_key = {inv0, inv1, inv2, inv3};

`ifdef AES_INV_KEY_CIPHER_KEY_EN
   logic [31:0]    fwd0, fwd1, fwd2, fwd3;
   logic [127:0]   fwd_key;

   // Forward schedule step used while walking from the cipher key up to
   // round 10; round_idx_q holds the round of the key currently stored.
   assign fwd0    = w0 ^ sub_rot(w3) ^ rcon_word(round_idx_q + 4'd1);
   assign fwd1    = w1 ^ fwd0;
   assign fwd2    = w2 ^ fwd1;
   assign fwd3    = w3 ^ fwd2;
   assign fwd_key = {fwd0, fwd1, fwd2, fwd3};
`endif

   // State register. Reset wins over anything else sampled on the same edge,
   // which also drops a start that coincides with reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. start is only looked at in IDLE, so a start pulse in
   // the middle of a schedule has no effect. PRECOMP leaves after the step
   // that produces round 10 (stored round 9 -> 10).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
`ifdef AES_INV_KEY_CIPHER_KEY_EN
               state_d = PRECOMP;
`else
               state_d = OUT;
`endif
            end
         end
         PRECOMP: begin
            if (round_idx_q == 4'd9) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (bus.key_ready && (round_idx_q == 4'd0)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Key datapath and done pulse. The key register only moves on a
   // handshake in OUT, so a stalled consumer sees a frozen key and index.
   // After round 0 is accepted the key is left untouched so the final key
   // stays visible while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         round_key_q <= '0;
         round_idx_q <= 4'd0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  round_key_q <= bus.key_in;
`ifdef AES_INV_KEY_CIPHER_KEY_EN
                  round_idx_q <= 4'd0;
`else
                  round_idx_q <= 4'd10;
`endif
               end
            end
`ifdef AES_INV_KEY_CIPHER_KEY_EN
            PRECOMP: begin
               round_key_q <= fwd_key;
               round_idx_q <= round_idx_q + 4'd1;
            end
`endif
            OUT: begin
               if (bus.key_ready) begin
                  if (round_idx_q == 4'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     round_key_q <= inv_key;
                     round_idx_q <= round_idx_q - 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.round_key = round_key_q;
   assign bus.round_idx = round_idx_q;
   assign bus.key_valid = (state_q == OUT);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_expand
// Self-checking bench for aes_inv_key_expand. The reference is a plain
// forward AES-128 key expansion (S-box derived from GF(2^8) inversion and
// the affine map) whose 11 round keys are expected in reverse order.
// Builds against either configuration of AES_INV_KEY_CIPHER_KEY_EN.
// ---------------------------------------------------------------------------
module tb_aes_inv_key_expand;

`ifdef AES_INV_KEY_CIPHER_KEY_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 1;
`endif

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK9 = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ALT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] POKE_KEY = 128'hffeeddccbbaa99887766554433221100;

   logic clk = 1'b0;
   logic rst_n;

   aes_inv_key_expand_if bus ();

   aes_inv_key_expand dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   logic [7:0]   tb_sbox [256];
   logic [127:0] model_rk [11];
   logic [127:0] seen [11];
   bit           mon_en = 1'b0;
   int           mon_idx;
   int           mon_phase;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      logic       hi;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         hi = aa[7];
         aa = {aa[6:0], 1'b0};
         if (hi) aa = aa ^ 8'h1b;
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // S-box = affine(inverse(x)), inverse found by exhaustive search.
   task automatic buildSbox();
      logic [7:0] xb;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         xb  = x[7:0];
         inv = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            end
         end
         tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Textbook forward expansion into 44 words, grouped into 11 round keys.
   task automatic expandKey(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      w[0] = k[127:96];
      w[1] = k[95:64];
      w[2] = k[63:32];
      w[3] = k[31:0];
      rc   = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
            t  = t ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) begin
         model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [127:0] k, input logic r);
      bus.start     = s;
      bus.key_in    = k;
      bus.key_ready = r;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Compare process: while a schedule is live, every cycle must show the
   // model key for the expected round; the round only advances on a
   // handshake, then one done cycle, then idle holding round 0.
   always @(negedge clk) begin
      if (!mon_en) begin
         mon_idx   = 10;
         mon_phase = 0;
      end else begin
         case (mon_phase)
            0: begin
               checkOutput("mon_valid", 128'(bus.key_valid), 128'(1));
               checkOutput("mon_busy", 128'(bus.busy), 128'(1));
               checkOutput("mon_done", 128'(bus.done), 128'(0));
               checkOutput("mon_idx", 128'(bus.round_idx), 128'(mon_idx));
               checkOutput("mon_key", bus.round_key, model_rk[mon_idx]);
               if (bus.key_ready) begin
                  if (mon_idx == 0) mon_phase = 1;
                  else mon_idx = mon_idx - 1;
               end
            end
            1: begin
               checkOutput("mon_done_pulse", 128'(bus.done), 128'(1));
               checkOutput("mon_valid_end", 128'(bus.key_valid), 128'(0));
               checkOutput("mon_busy_end", 128'(bus.busy), 128'(0));
               checkOutput("mon_idx_end", 128'(bus.round_idx), 128'(0));
               checkOutput("mon_key_end", bus.round_key, model_rk[0]);
               mon_phase = 2;
            end
            default: begin
               checkOutput("mon_done_idle", 128'(bus.done), 128'(0));
               checkOutput("mon_valid_idle", 128'(bus.key_valid), 128'(0));
               checkOutput("mon_idx_idle", 128'(bus.round_idx), 128'(0));
               checkOutput("mon_key_idle", bus.round_key, model_rk[0]);
            end
         endcase
      end
   end

   // Launch a schedule from a cipher key; the key actually driven depends
   // on the build. Returns once the first key is visible.
   task automatic startRun(input logic [127:0] cipher_key);
      logic [127:0] drive_key;
      int           lat;
      expandKey(cipher_key);
`ifdef AES_INV_KEY_CIPHER_KEY_EN
      drive_key = cipher_key;
`else
      drive_key = model_rk[10];
`endif
      applyStimulus(1'b1, drive_key, 1'b1);
      tick();
      applyStimulus(1'b0, drive_key, 1'b1);
      checkOutput("busy_after_start", 128'(bus.busy), 128'(1));
      lat = 1;
      while (!bus.key_valid && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput("first_valid_latency", 128'(lat), 128'(LAT));
      mon_en = 1'b1;
   endtask

   // Consume keys until done, optionally stalling, poking start or
   // stopping early at a chosen round.
   task automatic driveRun(input int stall_idx, input int stall_len, input int poke_idx,
                           input int abort_idx, output bit got_done, output int idx9_cycles,
                           output int done_gap);
      int   cyc;
      int   idx0_cyc;
      int   stalls;
      int   idx;
      bit   poked;
      bit   aborted;
      logic rdy;
      logic st;
      cyc = 0; idx0_cyc = -100; stalls = 0; poked = 0; aborted = 0;
      got_done = 0; idx9_cycles = 0; done_gap = -1;
      for (int n = 0; n < 80; n++) begin
         if (bus.done) begin
            got_done = 1;
            done_gap = cyc - idx0_cyc;
            break;
         end
         if (bus.key_valid) begin
            idx = int'(bus.round_idx);
            if (idx <= 10) seen[idx] = bus.round_key;
            if (idx == 9) idx9_cycles++;
            if (idx == 0) idx0_cyc = cyc;
            if (idx == abort_idx) begin
               aborted = 1;
               break;
            end
            rdy = !(idx == stall_idx && stalls < stall_len);
            if (!rdy) stalls++;
            st = (idx == poke_idx) && !poked;
            if (st) poked = 1;
            applyStimulus(st, st ? POKE_KEY : bus.key_in, rdy);
         end else begin
            applyStimulus(1'b0, bus.key_in, 1'b1);
         end
         tick();
         cyc++;
      end
      if (!got_done && !aborted) checkOutput("run_timeout", 128'(0), 128'(1));
      if (got_done) begin
         applyStimulus(1'b0, bus.key_in, 1'b1);
         tick();
         tick();
      end
      mon_en = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit got_done;
      int idx9_cycles;
      int done_gap;

      buildSbox();
      checkOutput("sbox_00", 128'(tb_sbox[8'h00]), 128'(8'h63));
      checkOutput("sbox_53", 128'(tb_sbox[8'h53]), 128'(8'hed));
      checkOutput("sbox_ff", 128'(tb_sbox[8'hff]), 128'(8'h16));

      // Reset state
      applyStimulus(1'b0, '0, 1'b1);
      rst_n = 1'b0;
      tick();
      tick();
      checkOutput("rst_round_key", bus.round_key, 128'(0));
      checkOutput("rst_round_idx", 128'(bus.round_idx), 128'(0));
      checkOutput("rst_key_valid", 128'(bus.key_valid), 128'(0));
      checkOutput("rst_busy", 128'(bus.busy), 128'(0));
      checkOutput("rst_done", 128'(bus.done), 128'(0));
      rst_n = 1'b1;
      tick();

      // Pin the model with the FIPS-197 example schedule
      expandKey(FIPS_KEY);
      checkOutput("model_rk10", model_rk[10], FIPS_RK10);
      checkOutput("model_rk9", model_rk[9], FIPS_RK9);
      checkOutput("model_rk1", model_rk[1], FIPS_RK1);
      checkOutput("model_rk0", model_rk[0], FIPS_KEY);

      // Full run with key_ready held high
      $display("[TB] run A: free-running FIPS schedule");
      startRun(FIPS_KEY);
      driveRun(-1, 0, -1, -1, got_done, idx9_cycles, done_gap);
      checkOutput("A_done_seen", 128'(got_done), 128'(1));
      checkOutput("A_done_gap", 128'(done_gap), 128'(1));
      checkOutput("A_idx10", seen[10], FIPS_RK10);
      checkOutput("A_idx9", seen[9], FIPS_RK9);
      checkOutput("A_idx1", seen[1], FIPS_RK1);
      checkOutput("A_idx0", seen[0], FIPS_KEY);

      // Consumer stalls for 5 cycles while round 9 is shown
      $display("[TB] run B: stall at round 9");
      startRun(FIPS_KEY);
      driveRun(9, 5, -1, -1, got_done, idx9_cycles, done_gap);
      checkOutput("B_done_seen", 128'(got_done), 128'(1));
      checkOutput("B_idx9_cycles", 128'(idx9_cycles), 128'(6));
      checkOutput("B_idx8", seen[8], model_rk[8]);

      // Start pulsed mid-schedule with another key must be ignored
      $display("[TB] run C: start poked at round 5");
      startRun(FIPS_KEY);
      driveRun(-1, 0, 5, -1, got_done, idx9_cycles, done_gap);
      checkOutput("C_done_seen", 128'(got_done), 128'(1));
      checkOutput("C_idx0", seen[0], FIPS_KEY);

      // Reset for one cycle while round 4 is shown
      $display("[TB] run D: reset at round 4");
      startRun(FIPS_KEY);
      driveRun(-1, 0, -1, 4, got_done, idx9_cycles, done_gap);
      rst_n = 1'b0;
      applyStimulus(1'b0, bus.key_in, 1'b1);
      tick();
      rst_n = 1'b1;
      checkOutput("D_rst_key", bus.round_key, 128'(0));
      checkOutput("D_rst_idx", 128'(bus.round_idx), 128'(0));
      checkOutput("D_rst_valid", 128'(bus.key_valid), 128'(0));
      checkOutput("D_rst_busy", 128'(bus.busy), 128'(0));
      checkOutput("D_rst_done", 128'(bus.done), 128'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("D_no_done", 128'(bus.done), 128'(0));
         checkOutput("D_idle_busy", 128'(bus.busy), 128'(0));
      end
      startRun(ALT_KEY);
      driveRun(-1, 0, -1, -1, got_done, idx9_cycles, done_gap);
      checkOutput("D_done_seen", 128'(got_done), 128'(1));
      checkOutput("D_idx0", seen[0], ALT_KEY);

      // Reset and start in the same cycle
      $display("[TB] run E: reset with start");
      rst_n = 1'b0;
      applyStimulus(1'b1, FIPS_RK10, 1'b1);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, FIPS_RK10, 1'b1);
      checkOutput("E_key", bus.round_key, 128'(0));
      checkOutput("E_valid", 128'(bus.key_valid), 128'(0));
      checkOutput("E_busy", 128'(bus.busy), 128'(0));
      tick();
      checkOutput("E_busy_next", 128'(bus.busy), 128'(0));
      checkOutput("E_valid_next", 128'(bus.key_valid), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
